// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
// Holds the opcode enumeration, the FSM state type and the default
// datapath/address widths. The MUL state exists only when the
// EXEC_STAGE_MUL_EN macro is defined.
package exec_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_MUL  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

`ifdef EXEC_STAGE_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/exec_stage_if.sv
// Operation/writeback bundle of the execute stage.
// master: upstream + register-file side (drives in_valid/op/rd0/rd1/dst,
//         observes in_ready, we/a2/wd and the flags).
// slave : the execute stage itself.
interface exec_stage_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic [AW-1:0]    dst;
  logic             we;
  logic [AW-1:0]    a2;
  logic [WIDTH-1:0] wd;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output in_valid, op, rd0, rd1, dst,
    input  in_ready, we, a2, wd, flag_z, flag_c
  );

  modport slave (
    input  in_valid, op, rd0, rd1, dst,
    output in_ready, we, a2, wd, flag_z, flag_c
  );
endinterface

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports: clock, reset (async, active-high); start loads a/b; busy is high
// for WIDTH cycles; done marks the last of those cycles, during which
// product already carries the final (low WIDTH bits) result.
module exec_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // product is the accumulator after the current step, so the caller can
  // register it on the same edge that consumes the final multiplier bit.
  assign product = acc_next;
  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/exec_stage.sv
// Execute stage: accepts one operation when idle, computes it and issues a
// single register-file write, updating zero/carry flags as it leaves WB.
// Ports: clock, reset (async, active-high), bus (exec_stage_if.slave:
// in_valid/in_ready handshake, op/rd0/rd1/dst operation, we/a2/wd write
// port, flag_z/flag_c).
// Macro EXEC_STAGE_MUL_EN: compiles in the iterative multiplier and the MUL
// state; without it op 6 is accepted and silently dropped.
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input logic         clock,
  input logic         reset,
  exec_stage_if.slave bus
);
  state_t           state;
  logic             we_q;
  logic [AW-1:0]    a2_q;
  logic [WIDTH-1:0] wd_q;
  logic             z_q;
  logic             c_q;
  logic             arith_q;
  logic             carry_q;

  logic             accept;
  op_t              op_in;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign op_in  = op_t'(bus.op);
  assign accept = (state == S_IDLE) && bus.in_valid;

  always_comb begin
    ext       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_in)
      OP_ADD: begin
        ext       = {1'b0, bus.rd0} + {1'b0, bus.rd1};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow out.
        ext       = {1'b0, bus.rd0} - {1'b0, bus.rd1};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
      end
      OP_AND:  alu_res = bus.rd0 & bus.rd1;
      OP_OR:   alu_res = bus.rd0 | bus.rd1;
      OP_XOR:  alu_res = bus.rd0 ^ bus.rd1;
      OP_SHL:  alu_res = bus.rd0 << bus.rd1[2:0];
      OP_MUL:  alu_res = '0;
      OP_PASS: alu_res = bus.rd0;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EN
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (op_in == OP_MUL);

  exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.rd0),
    .b       (bus.rd1),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      a2_q    <= '0;
      wd_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      arith_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef EXEC_STAGE_MUL_EN
            a2_q    <= bus.dst;
            arith_q <= (op_in == OP_ADD) || (op_in == OP_SUB);
            carry_q <= alu_carry;
            if (op_in == OP_MUL) begin
              state <= S_MUL;
            end else begin
              state <= S_WB;
              we_q  <= 1'b1;
              wd_q  <= alu_res;
            end
`else
            if (op_in != OP_MUL) begin
              a2_q    <= bus.dst;
              arith_q <= (op_in == OP_ADD) || (op_in == OP_SUB);
              carry_q <= alu_carry;
              state   <= S_WB;
              we_q    <= 1'b1;
              wd_q    <= alu_res;
            end
`endif
          end
        end
`ifdef EXEC_STAGE_MUL_EN
        S_MUL: begin
          if (mul_done) begin
            state <= S_WB;
            we_q  <= 1'b1;
            wd_q  <= mul_product;
          end else if (!mul_busy) begin
            // Multiplier idle without finishing: recover rather than hang.
            state <= S_IDLE;
          end
        end
`endif
        S_WB: begin
          // Flags are committed only once the write completes, so a reset
          // that cuts WB short leaves them untouched by the abandoned op.
          state <= S_IDLE;
          we_q  <= 1'b0;
          z_q   <= (wd_q == '0);
          if (arith_q) c_q <= carry_q;
        end
        default: begin
          state <= S_IDLE;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.we       = we_q;
  assign bus.a2       = a2_q;
  assign bus.wd       = wd_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed vectors for ALU ops, flags,
// multiply (or its drop when compiled out), reset mid-operation and
// backpressure, plus a count of write pulses against issued operations.
module tb_exec_stage;
  logic clock;
  logic reset;

  int total;
  int bad;
  int wcount;
  int exp_writes;

  exec_stage_if #(.WIDTH(8), .AW(8)) bus ();

  exec_stage #(.WIDTH(8), .AW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts cycles in which the write enable was high at the rising edge.
  initial wcount = 0;
  always @(posedge clock) if (bus.we === 1'b1) wcount++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.rd0      = a;
    bus.rd1      = b;
    bus.dst      = d;
  endtask

  // Issue a non-MUL op from IDLE and check the write cycle and the flags after.
  task automatic alu_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] d, input logic [7:0] res,
                        input logic z, input logic c);
    offer(o, a, b, d);
    tick();
    bus.in_valid = 1'b0;
    exp_writes++;
    check({tag, "_we"}, bus.we, 1);
    check({tag, "_a2"}, bus.a2, d);
    check({tag, "_wd"}, bus.wd, res);
    check({tag, "_rdy_wb"}, bus.in_ready, 0);
    tick();
    check({tag, "_we_off"}, bus.we, 0);
    check({tag, "_rdy"}, bus.in_ready, 1);
    check({tag, "_z"}, bus.flag_z, z);
    check({tag, "_c"}, bus.flag_c, c);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_writes = 0;
    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.rd0 = '0;
    bus.rd1 = '0;
    bus.dst = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_we", bus.we, 0);
    check("rst_a2", bus.a2, 0);
    check("rst_wd", bus.wd, 0);
    check("rst_z", bus.flag_z, 0);
    check("rst_c", bus.flag_c, 0);
    reset = 1'b0;
    check("rst_rdy_first", bus.in_ready, 1);

    // ALU ops; flag_c tracked across ADD/SUB and held on logic ops.
    alu_op("add",  3'd0, 8'd200, 8'd100, 8'd2,  8'd44,   1'b0, 1'b1);
    alu_op("sub0", 3'd1, 8'd5,   8'd5,   8'd30, 8'd0,    1'b1, 1'b0);
    alu_op("subb", 3'd1, 8'd3,   8'd5,   8'd31, 8'hFE,   1'b0, 1'b1);
    alu_op("shl",  3'd5, 8'h07,  8'd3,   8'd4,  8'h38,   1'b0, 1'b1);
    alu_op("and",  3'd2, 8'hF0,  8'h3C,  8'd5,  8'h30,   1'b0, 1'b1);
    alu_op("or",   3'd3, 8'hF0,  8'h3C,  8'd6,  8'hFC,   1'b0, 1'b1);
    alu_op("xorz", 3'd4, 8'h5A,  8'h5A,  8'd8,  8'h00,   1'b1, 1'b1);
    alu_op("pass", 3'd7, 8'hA5,  8'h11,  8'd9,  8'hA5,   1'b0, 1'b1);
    alu_op("shlw", 3'd5, 8'h81,  8'd9,   8'd3,  8'h02,   1'b0, 1'b1);

    // Multiply 13*11 into r7.
    offer(3'd6, 8'd13, 8'd11, 8'd7);
    tick();
    bus.in_valid = 1'b0;
`ifdef EXEC_STAGE_MUL_EN
    for (int i = 1; i <= 8; i++) begin
      check("mul_busy_rdy", bus.in_ready, 0);
      check("mul_busy_we", bus.we, 0);
      tick();
    end
    exp_writes++;
    check("mul_we", bus.we, 1);
    check("mul_a2", bus.a2, 7);
    check("mul_wd", bus.wd, 143);
    check("mul_rdy_wb", bus.in_ready, 0);
    tick();
    check("mul_rdy", bus.in_ready, 1);
    check("mul_z", bus.flag_z, 0);
    check("mul_c", bus.flag_c, 1);
`else
    for (int i = 1; i <= 10; i++) begin
      check("nomul_rdy", bus.in_ready, 1);
      check("nomul_we", bus.we, 0);
      tick();
    end
    check("nomul_z", bus.flag_z, 0);
    check("nomul_c", bus.flag_c, 1);
`endif

    // Reset three cycles into a multiply: nothing may be written.
    offer(3'd6, 8'd13, 8'd11, 8'd7);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rmul_we", bus.we, 0);
    check("rmul_a2", bus.a2, 0);
    check("rmul_wd", bus.wd, 0);
    check("rmul_z", bus.flag_z, 0);
    check("rmul_c", bus.flag_c, 0);
    tick();
    reset = 1'b0;
    check("rmul_rdy", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) tick();
    check("rmul_nowrite", bus.we, 0);

    // Reset landing in the WB cycle cuts the write short.
    offer(3'd0, 8'd1, 8'd255, 8'd12);
    tick();
    bus.in_valid = 1'b0;
    check("rwb_we_before", bus.we, 1);
    reset = 1'b1;
    #1;
    check("rwb_we", bus.we, 0);
    check("rwb_c", bus.flag_c, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rwb_rdy", bus.in_ready, 1);
    check("rwb_c_hold", bus.flag_c, 0);

    // Backpressure: a new op offered during WB waits for the next IDLE cycle.
    offer(3'd0, 8'd1, 8'd2, 8'd9);
    tick();
    exp_writes++;
    check("bp_we1", bus.we, 1);
    check("bp_wd1", bus.wd, 3);
    check("bp_a21", bus.a2, 9);
    offer(3'd4, 8'hFF, 8'h0F, 8'd10);
    tick();
    check("bp_gap_we", bus.we, 0);
    check("bp_gap_rdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    exp_writes++;
    check("bp_we2", bus.we, 1);
    check("bp_wd2", bus.wd, 8'hF0);
    check("bp_a22", bus.a2, 10);
    tick();
    check("bp_we2_off", bus.we, 0);
    tick();
    check("bp_idle_we", bus.we, 0);

    check("write_count", wcount, exp_writes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands, result and register-file write data.
REQ-002 Parameter AW, default 8, register-file address width.
REQ-003 clock  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation offered this cycle.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 PASS.
REQ-008 rd0  input  WIDTH  operand A, from register-file read port 0.
REQ-009 rd1  input  WIDTH  operand B, from register-file read port 1.
REQ-010 dst  input  AW  destination register address.
REQ-011 we  output  1  register-file write enable.
REQ-012 a2  output  AW  register-file write address.
REQ-013 wd  output  WIDTH  register-file write data.
REQ-014 flag_z  output  1  last written result was zero.
REQ-015 flag_c  output  1  carry out of last ADD, or borrow out of last SUB.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, MUL, WB.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 An operation SHALL be accepted on the edge where in_valid and in_ready are both 1.
- On acceptance, op, rd0, rd1 and dst SHALL be captured.
- Inputs SHALL be ignored in every other cycle.
REQ-019 Non-MUL op accepted at edge N: IDLE->WB; we=1 during cycle N+1 only; WB->IDLE at edge N+1.
REQ-020 Results, truncated to WIDTH:
- ADD = A+B; SUB = A-B; AND, OR, XOR bitwise.
- SHL = A << B[2:0], zero fill.
- PASS = A.
REQ-021 MUL (when compiled in):
- IDLE->MUL; iterative shift-add, one multiplier bit per cycle, LSB first.
- After exactly WIDTH cycles in MUL -> WB.
- wd = low WIDTH bits of the product; we=1 during cycle N+1+WIDTH.
REQ-022 While we=1, a2 SHALL equal the captured dst and wd the result; outside WB, we SHALL be 0.
REQ-023 flag_z SHALL update at the edge leaving WB and hold otherwise.
REQ-024 flag_c SHALL update only on ADD/SUB writes; on other ops it SHALL hold.
REQ-025 in_valid while not in IDLE SHALL be ignored with no side effect; upstream holds the operation until in_ready.
REQ-026 Back-to-back non-MUL ops SHALL sustain one write every 2 cycles.

Reset
REQ-027 reset SHALL force state IDLE and we=0, a2=0, wd=0, flag_z=0, flag_c=0 immediately.
REQ-028 reset asserted in MUL or WB SHALL abandon the operation with no write, including a WB cycle cut short.
REQ-029 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 Macro EXEC_STAGE_MUL_EN defined: MUL behaves per REQ-021.
REQ-031 Macro EXEC_STAGE_MUL_EN undefined:
- The MUL state and datapath SHALL be absent.
- Op 6 SHALL be accepted and dropped with no write; flags hold; in_ready stays 1.

Structure
REQ-032 A shared package exec_pkg SHALL hold:
- the opcode enumeration;
- the FSM state typedef;
- the default WIDTH and AW constants.
REQ-033 The iterative multiplier SHALL be a sub-module exec_mul (start, busy/done, WIDTH parameter), instantiated only under EXEC_STAGE_MUL_EN.

Verification
REQ-034 Required directed scenarios, each stimulus -> required response:
- ADD: rd0=200, rd1=100, dst=2, accepted at N -> cycle N+1: we=1, a2=2, wd=44; flag_c=1, flag_z=0.
- SUB: rd0=5, rd1=5, dst=30 -> wd=0, flag_z=1, flag_c=0.
- SHL: rd0=8'b0000_0111, rd1=3 -> wd=8'b0011_1000.
- MUL (EXEC_STAGE_MUL_EN): rd0=13, rd1=11, dst=7 -> in_ready=0 for 9 cycles; we=1 at N+9, wd=143. Without the macro: no write, in_ready=1 throughout.
- Reset in MUL: reset pulsed 3 cycles after MUL acceptance -> no we pulse; all outputs 0; in_ready=1 after deassertion.
- Backpressure: in_valid held high with a new op during WB -> op accepted only on the following IDLE cycle; exactly one write per op.
